// File: rtl/lutram_stress_seq.sv
// rtl/lutram_stress_seq.sv - March-test sequencer and read-back checker for the LUTRAM array
module lutram_stress_seq #(
    parameter int         LUTRAM16X10 = 10,
    parameter int         RD_LAT      = 1,
    parameter logic [9:0] SEED        = 10'h2A5,
    localparam int        DEPTH       = LUTRAM16X10 * 16,
    localparam int        AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          loop,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic [15:0]   pass_cnt,
    output logic [AW-1:0] addr,
    output logic          we,
    output logic [9:0]    wdat,
    input  logic [9:0]    rdat
);

    typedef enum logic [2:0] {
        S_IDLE, S_W0, S_R0, S_D0, S_W1, S_R1, S_D1, S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST       = AW'(DEPTH - 1);
    localparam logic [1:0]    DRAIN_LAST = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

    function automatic logic [9:0] pat(input logic [AW-1:0] a);
        return SEED ^ 10'(a);
    endfunction

    state_t        state, state_d;
    logic [AW-1:0] addr_d;
    logic [1:0]    drain, drain_d;
    logic          we_d;
    logic [9:0]    wdat_d;
    logic          clear, pass_end;

    always_comb begin
        state_d  = state;
        addr_d   = addr;
        drain_d  = drain;
        clear    = 1'b0;
        pass_end = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_W0;
                    addr_d  = '0;
                    clear   = 1'b1;
                end
            end
            S_W0: begin
                if (addr == LAST) begin
                    state_d = S_R0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr + 1'b1;
                end
            end
            S_R0: begin
                // addr is already DEPTH-1 here, which is where W1 starts
                if (addr == LAST) begin
                    drain_d = '0;
                    state_d = (RD_LAT == 0) ? S_W1 : S_D0;
                end else begin
                    addr_d = addr + 1'b1;
                end
            end
            S_D0: begin
                if (drain == DRAIN_LAST) state_d = S_W1;
                else                     drain_d = drain + 1'b1;
            end
            S_W1: begin
                if (addr == '0) begin
                    state_d = S_R1;
                    addr_d  = LAST;
                end else begin
                    addr_d = addr - 1'b1;
                end
            end
            S_R1: begin
                if (addr == '0) begin
                    drain_d = '0;
                    if (RD_LAT == 0) pass_end = 1'b1;
                    else             state_d  = S_D1;
                end else begin
                    addr_d = addr - 1'b1;
                end
            end
            S_D1: begin
                if (drain == DRAIN_LAST) pass_end = 1'b1;
                else                     drain_d  = drain + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (pass_end) begin
            state_d = loop ? S_W0 : S_DONE;
            addr_d  = '0;
        end

        we_d   = (state_d == S_W0) || (state_d == S_W1);
        wdat_d = '0;
        if (state_d == S_W0) wdat_d = pat(addr_d);
        if (state_d == S_W1) wdat_d = ~pat(addr_d);
    end

    // Read issue in the current cycle, and the entry that meets rdat at this edge
    logic          issue_v;
    logic [9:0]    issue_exp;
    logic          tap_v;
    logic [9:0]    tap_exp;
    logic [AW-1:0] tap_addr;

    assign issue_v   = (state == S_R0) || (state == S_R1);
    assign issue_exp = (state == S_R1) ? ~pat(addr) : pat(addr);

    generate
        if (RD_LAT == 0) begin : g_direct
            assign tap_v    = issue_v;
            assign tap_exp  = issue_exp;
            assign tap_addr = addr;
        end else begin : g_delay
            logic [RD_LAT-1:0] line_v;
            logic [9:0]        line_exp  [RD_LAT];
            logic [AW-1:0]     line_addr [RD_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    line_v <= '0;
                end else begin
                    line_v[0] <= issue_v;
                    for (int i = 1; i < RD_LAT; i++) line_v[i] <= line_v[i-1];
                end
                line_exp[0]  <= issue_exp;
                line_addr[0] <= addr;
                for (int i = 1; i < RD_LAT; i++) begin
                    line_exp[i]  <= line_exp[i-1];
                    line_addr[i] <= line_addr[i-1];
                end
            end

            assign tap_v    = line_v[RD_LAT-1];
            assign tap_exp  = line_exp[RD_LAT-1];
            assign tap_addr = line_addr[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            addr           <= '0;
            we             <= 1'b0;
            wdat           <= '0;
            drain          <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass_cnt       <= '0;
        end else begin
            state <= state_d;
            addr  <= addr_d;
            we    <= we_d;
            wdat  <= wdat_d;
            drain <= drain_d;
            if (clear) begin
                err_cnt        <= '0;
                first_err_addr <= '0;
                pass_cnt       <= '0;
            end else begin
                if (tap_v && (rdat != tap_exp)) begin
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    if (err_cnt == 16'd0)    first_err_addr <= tap_addr;
                end
                if (pass_end) pass_cnt <= pass_cnt + 16'd1;
            end
        end
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);
    assign pass = (err_cnt == 16'd0);

endmodule

// File: tb/tb_lutram_stress_seq.sv
// tb/tb_lutram_stress_seq.sv - Randomized model-checked bench for lutram_stress_seq
module tb_lutram_stress_seq;

    localparam int         D    = 160;
    localparam int         AW   = 8;
    localparam logic [9:0] SEED = 10'h2A5;
    localparam int         L    = 1;
    localparam int         PLEN = 4*D + 2*L;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, loop;

    logic          busy, done, pass, we;
    logic [15:0]   err_cnt, pass_cnt;
    logic [AW-1:0] first_err_addr, addr;
    logic [9:0]    wdat, rdat;

    logic          busy0, done0, pass0, we0;
    logic [15:0]   err0, pcnt0;
    logic [AW-1:0] first0, addr0;
    logic [9:0]    wdat0, rdat0;

    logic          busy3, done3, pass3, we3;
    logic [15:0]   err3, pcnt3;
    logic [AW-1:0] first3, addr3;
    logic [9:0]    wdat3, rdat3;

    lutram_stress_seq #(.LUTRAM16X10(10), .RD_LAT(L), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .loop(loop),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .pass_cnt(pass_cnt),
        .addr(addr), .we(we), .wdat(wdat), .rdat(rdat));

    lutram_stress_seq #(.LUTRAM16X10(10), .RD_LAT(0), .SEED(SEED)) dut0 (
        .clk(clk), .rst(rst), .start(start), .loop(loop),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_err_addr(first0), .pass_cnt(pcnt0),
        .addr(addr0), .we(we0), .wdat(wdat0), .rdat(rdat0));

    lutram_stress_seq #(.LUTRAM16X10(10), .RD_LAT(3), .SEED(SEED)) dut3 (
        .clk(clk), .rst(rst), .start(start), .loop(loop),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
        .first_err_addr(first3), .pass_cnt(pcnt3),
        .addr(addr3), .we(we3), .wdat(wdat3), .rdat(rdat3));

    function automatic logic [9:0] pat(input int a);
        return SEED ^ 10'(a);
    endfunction

    // Ideal arrays for the latency-0 and latency-3 instances
    logic [9:0] mem0 [D];
    logic [9:0] mem3 [D];
    logic [9:0] p3a, p3b, p3c;
    assign rdat0 = mem0[addr0];
    assign rdat3 = p3c;
    always @(posedge clk) begin
        if (we0) mem0[addr0] <= wdat0;
        if (we3) mem3[addr3] <= wdat3;
        p3a <= mem3[addr3];
        p3b <= p3a;
        p3c <= p3b;
    end

    // Fault configuration for the main instance: masks flip bits on R0 / R1 reads
    logic [9:0] c0 [D];
    logic [9:0] c1 [D];
    logic       force9;

    // Main array and pass-level reference model
    logic [9:0] mem1 [D];
    logic [9:0] rv;
    int  m_t, m_err, m_first, m_pcnt;
    logic m_busy, m_done;
    int  bc1, bc0, bc3;

    task automatic end_of_pass();
        int perr, pf;
        perr = 0;
        pf   = -1;
        if (force9) begin
            perr = D;
            pf   = 0;
        end else begin
            for (int a = 0; a < D; a++)
                if (c0[a] != 10'd0) begin perr++; if (pf < 0) pf = a; end
            for (int a = D-1; a >= 0; a--)
                if (c1[a] != 10'd0) begin perr++; if (pf < 0) pf = a; end
        end
        if (m_err == 0 && perr > 0) m_first = pf;
        m_err = (m_err + perr > 65535) ? 65535 : m_err + perr;
        m_pcnt++;
    endtask

    always @(posedge clk) begin
        rv = mem1[addr] ^ ((m_busy && m_t < 2*D) ? c0[addr] : c1[addr]);
        if (force9) rv[9] = 1'b0;
        rdat <= rv;
        if (we) mem1[addr] <= wdat;

        if (start && !busy)  bc1 = 0; else if (busy)  bc1++;
        if (start && !busy0) bc0 = 0; else if (busy0) bc0++;
        if (start && !busy3) bc3 = 0; else if (busy3) bc3++;

        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_t = 0;
            m_err = 0; m_first = 0; m_pcnt = 0;
        end else if (m_busy) begin
            if (m_t == PLEN-1) begin
                end_of_pass();
                m_t = 0;
                if (!loop) begin m_busy = 1'b0; m_done = 1'b1; end
            end else begin
                m_t++;
            end
        end else if (start) begin
            m_busy = 1'b1; m_done = 1'b0; m_t = 0;
            m_err = 0; m_first = 0; m_pcnt = 0;
        end
    end

    int   n_chk, n_fail;
    logic chk_en;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Per-cycle comparison of the main instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int   t, ea;
            logic ok;
            t  = m_t;
            ea = 0;
            ok = (busy === m_busy) && (done === m_done) && (pass_cnt === 16'(m_pcnt));
            if (m_busy && t < D) begin
                ea = t;
                ok = ok && we && (addr == ea) && (wdat == pat(ea));
            end else if (m_busy && t < 2*D) begin
                ea = t - D;
                ok = ok && !we && (addr == ea);
            end else if (m_busy && t < 2*D + L) begin
                ok = ok && !we;
            end else if (m_busy && t < 3*D + L) begin
                ea = D - 1 - (t - 2*D - L);
                ok = ok && we && (addr == ea) && (wdat == ~pat(ea));
            end else if (m_busy && t < 4*D + L) begin
                ea = D - 1 - (t - 3*D - L);
                ok = ok && !we && (addr == ea);
            end else begin
                ok = ok && !we;
            end
            if (m_done)
                ok = ok && (err_cnt == 16'(m_err)) && (first_err_addr == AW'(m_first))
                        && (pass == (m_err == 0));
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL cycle_model t=%0d busy=%b/%b done=%b/%b we=%b addr=%0d/%0d wdat=%h pass_cnt=%0d/%0d err_cnt=%0d/%0d first=%0d/%0d",
                         t, busy, m_busy, done, m_done, we, addr, ea, wdat,
                         pass_cnt, m_pcnt, err_cnt, m_err, first_err_addr, m_first);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!(done && done0 && done3) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("run_finished", int'(done && done0 && done3), 1);
    endtask

    task automatic check_run(input int np, input int e_err, input int e_first);
        check("busy_cycles_lat1", bc1, np * PLEN);
        check("busy_cycles_lat0", bc0, np * 640);
        check("busy_cycles_lat3", bc3, np * 646);
        check("pass_lat0", int'(pass0), 1);
        check("pass_lat3", int'(pass3), 1);
        check("pass_cnt", int'(pass_cnt), np);
        check("err_cnt", int'(err_cnt), e_err);
        if (e_err != 0) check("first_err_addr", int'(first_err_addr), e_first);
        check("pass", int'(pass), int'(e_err == 0));
    endtask

    task automatic clear_faults();
        for (int a = 0; a < D; a++) begin c0[a] = 10'd0; c1[a] = 10'd0; end
        force9 = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; chk_en = 1'b0;
        bc1 = 0; bc0 = 0; bc3 = 0;
        m_busy = 1'b0; m_done = 1'b0; m_t = 0; m_err = 0; m_first = 0; m_pcnt = 0;
        rst = 1'b1; start = 1'b0; loop = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);

        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 1);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_first", int'(first_err_addr), 0);
        check("rst_pass_cnt", int'(pass_cnt), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_we", int'(we), 0);
        check("rst_wdat", int'(wdat), 0);

        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Clean pass with literal landmarks
        do_start();
        check("w0_addr", int'(addr), 0);
        check("w0_we", int'(we), 1);
        check("w0_wdat", int'(wdat), 'h2A5);
        repeat (2*D + L) @(negedge clk);
        check("w1_addr", int'(addr), 159);
        check("w1_we", int'(we), 1);
        check("w1_wdat", int'(wdat), 'h1C5);
        wait_done();
        check_run(1, 0, 0);

        // Single flipped bit on the R0 read of address 37
        c0[37] = 10'h001;
        do_start();
        wait_done();
        check_run(1, 1, 37);
        clear_faults();

        // rdat[9] stuck low: every R0 read fails, every R1 read passes
        force9 = 1'b1;
        do_start();
        wait_done();
        check_run(1, 160, 0);
        clear_faults();

        // Random bit flips on random R0/R1 reads
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                int a, b;
                a = $urandom_range(0, D-1);
                b = $urandom_range(0, 9);
                if ($urandom_range(0, 1) == 0) c0[a] = c0[a] | (10'd1 << b);
                else                           c1[a] = c1[a] | (10'd1 << b);
            end
            do_start();
            wait_done();
            check_run(1, m_err, m_first);
            clear_faults();
        end

        // Three looped passes, errors accumulate
        force9 = 1'b1;
        loop = 1'b1;
        do_start();
        begin
            int k;
            k = 0;
            while (pass_cnt != 16'd2 && k < 3000) begin @(negedge clk); k++; end
            check("loop_reached_pass2", int'(pass_cnt), 2);
            check("loop_not_done", int'(done), 0);
        end
        repeat (100) @(negedge clk);
        loop = 1'b0;
        wait_done();
        check_run(3, 480, 0);
        clear_faults();

        // Reset in the middle of W1, after R0 has logged errors
        force9 = 1'b1;
        do_start();
        repeat (330) @(negedge clk);
        check("midw1_we", int'(we), 1);
        check("midw1_err_cnt", int'(err_cnt), 160);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_we", int'(we), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_done", int'(done), 0);
        check("mrst_err_cnt", int'(err_cnt), 0);
        check("mrst_first", int'(first_err_addr), 0);
        check("mrst_pass_cnt", int'(pass_cnt), 0);
        check("mrst_addr", int'(addr), 0);
        check("mrst_wdat", int'(wdat), 0);
        check("mrst_pass", int'(pass), 1);
        rst = 1'b0;
        clear_faults();
        @(negedge clk);
        do_start();
        wait_done();
        check_run(1, 0, 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
